// File: rtl/rns_mac_accumulator_pkg.sv
// Shared RNS types and helpers for the RNS multiply-accumulate slice.
// Residue width, channel count and the modular-add primitive live here.
package rns_pkg;

  localparam int RES_W  = 8;
  localparam int NUM_CH = 4;
  localparam int RNS_W  = 32;

  typedef logic [NUM_CH-1:0][RES_W-1:0] rns_word_t;

  // Both operands are already reduced, so one conditional subtract suffices.
  // The 9-bit sum keeps the subtract meaningful even for a modulus of 256.
  function automatic logic [RES_W-1:0] mod_add(
    input logic [RES_W-1:0] a,
    input logic [RES_W-1:0] b,
    input logic [RES_W:0]   m
  );
    logic [RES_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= m) s = s - m;
    return s[RES_W-1:0];
  endfunction

endpackage

// File: rtl/rns_mac_accumulator_lane.sv
// One residue channel of the RNS MAC: reduced product register and
// modular accumulator for modulus M.
module rns_mac_lane
  import rns_pkg::*;
#(
  parameter int M = 251
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [RES_W-1:0] x1,
  input  logic [RES_W-1:0] x2,
  input  logic             update,
  input  logic             first,
  output logic [RES_W-1:0] acc_next
);

  localparam logic [RES_W:0]     MOD   = (RES_W+1)'(M);
  localparam logic [2*RES_W-1:0] MOD_P = (2*RES_W)'(M);

  logic [2*RES_W-1:0] prod;
  logic [RES_W-1:0]   prod_mod;
  logic [RES_W-1:0]   p;
  logic [RES_W-1:0]   acc;

  assign prod     = {{RES_W{1'b0}}, x1} * {{RES_W{1'b0}}, x2};
  // Reducing the full product also folds unreduced input residues.
  assign prod_mod = RES_W'(prod % MOD_P);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p   <= '0;
      acc <= '0;
    end else begin
      if (load)   p   <= prod_mod;
      if (update) acc <= acc_next;
    end
  end

  assign acc_next = mod_add(first ? '0 : acc, p, MOD);

endmodule

// File: rtl/rns_mac_accumulator.sv
// Pipelined RNS multiply-accumulate: product stage, accumulate stage, and a
// registered per-frame result. Optional residue range checking under
// RNS_RESIDUE_CHECK_EN adds the sticky in_err output.
module rns_mac_accumulator
  import rns_pkg::*;
#(
  parameter int B0    = 251,
  parameter int B1    = 241,
  parameter int B2    = 239,
  parameter int B3    = 233,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [RNS_W-1:0] in_x1,
  input  logic [RNS_W-1:0] in_x2,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RNS_W-1:0] out_acc,
  output logic [CNT_W-1:0] out_count
`ifdef RNS_RESIDUE_CHECK_EN
  ,
  output logic             in_err
`endif
);

  localparam int             MODS [NUM_CH] = '{B0, B1, B2, B3};
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  logic             adv;
  logic             accept;
  logic             fire;
  logic             p_valid;
  logic             p_last;
  logic             first;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  rns_word_t        x1_w;
  rns_word_t        x2_w;
  rns_word_t        acc_next;

  // A stalled output register freezes every stage behind it.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign accept   = in_valid && adv;
  assign fire     = adv && p_valid;

  assign x1_w = in_x1;
  assign x2_w = in_x2;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
    rns_mac_lane #(
      .M (MODS[g])
    ) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (accept),
      .x1       (x1_w[g]),
      .x2       (x2_w[g]),
      .update   (fire),
      .first    (first),
      .acc_next (acc_next[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_valid <= 1'b0;
      p_last  <= 1'b0;
    end else if (adv) begin
      p_valid <= accept;
      if (accept) p_last <= in_last;
    end
  end

  assign cnt_next = first ? CNT_W'(1) : ((cnt == CNT_MAX) ? cnt : cnt + 1'b1);

  // NOTE: every control and output flop has an explicit reset value; a
  // mid-frame reset must leave first set so the next beat opens a new frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first     <= 1'b1;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_acc   <= '0;
      out_count <= '0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (fire) begin
        cnt   <= cnt_next;
        first <= p_last;
        if (p_last) begin
          out_acc   <= acc_next;
          out_count <= cnt_next;
          out_valid <= 1'b1;
        end
      end
    end
  end

`ifdef RNS_RESIDUE_CHECK_EN
  logic res_bad;

  // NOTE: the default assignment ahead of the loop keeps this combinational
  // block free of inferred latches.
  always_comb begin
    res_bad = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (({1'b0, x1_w[i]} >= (RES_W+1)'(MODS[i])) ||
          ({1'b0, x2_w[i]} >= (RES_W+1)'(MODS[i])))
        res_bad = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  in_err <= 1'b0;
    else if (accept && res_bad)  in_err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_rns_mac_accumulator.sv
// Self-checking bench for rns_mac_accumulator: a reference model pushes
// expected frame results to a queue; a monitor pops them on each handshake.
module tb_rns_mac_accumulator;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int MODS [4] = '{251, 241, 239, 233};

  typedef struct packed {
    logic [31:0]      acc;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_x1;
  logic [31:0]      in_x2;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_acc;
  logic [CNT_W-1:0] out_count;
`ifdef RNS_RESIDUE_CHECK_EN
  logic             in_err;
`endif

  rns_mac_accumulator #(
    .B0 (251), .B1 (241), .B2 (239), .B3 (233), .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x1     (in_x1),
    .in_x2     (in_x2),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_acc   (out_acc),
    .out_count (out_count)
`ifdef RNS_RESIDUE_CHECK_EN
    ,
    .in_err    (in_err)
`endif
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t exp_q[$];

  int   m_acc [4];
  int   m_cnt;
  bit   m_first;
  bit   m_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_first = 1'b1;
    m_cnt   = 0;
    m_err   = 1'b0;
    for (int i = 0; i < 4; i++) m_acc[i] = 0;
  endtask

  task automatic model_beat(input logic [31:0] a, input logic [31:0] b, input logic last);
    exp_t e;
    int   xa, xb, p;
    for (int i = 0; i < 4; i++) begin
      xa = int'(a[8*i +: 8]);
      xb = int'(b[8*i +: 8]);
      if (xa >= MODS[i] || xb >= MODS[i]) m_err = 1'b1;
      p = (xa * xb) % MODS[i];
      m_acc[i] = m_first ? p : (m_acc[i] + p) % MODS[i];
    end
    m_cnt   = m_first ? 1 : ((m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX);
    m_first = last;
    if (last) begin
      for (int i = 0; i < 4; i++) e.acc[8*i +: 8] = 8'(m_acc[i]);
      e.cnt = CNT_W'(m_cnt);
      exp_q.push_back(e);
    end
  endtask

  task automatic send_beat(input logic [31:0] a, input logic [31:0] b, input logic last);
    int guard;
    guard = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_x1    = a;
    in_x2    = b;
    in_last  = last;
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
    end else begin
      @(posedge clk);
      model_beat(a, b, last);
    end
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
`ifdef RNS_RESIDUE_CHECK_EN
    check("in_err", 32'(in_err), 32'(m_err));
`endif
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_in_ready"},  32'(in_ready),  32'd1);
    check({tag, "_out_acc"},   out_acc,        32'd0);
    check({tag, "_out_count"}, 32'(out_count), 32'd0);
`ifdef RNS_RESIDUE_CHECK_EN
    check({tag, "_in_err"},    32'(in_err),    32'd0);
`endif
  endtask

  // Monitor: each output handshake pops and checks one expected frame.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("out_acc",   out_acc,           e.acc);
        check("out_count", 32'(out_count),    32'(e.cnt));
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_x1     = '0;
    in_x2     = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    rst_n = 1'b1;

    // Single beat with latency check: out_valid rises two cycles after accept.
    send_beat(32'h05050505, 32'h07070707, 1'b1);
    @(negedge clk);
    check("lat_t1_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("lat_t2_out_valid", 32'(out_valid), 32'd1);
    check("single_acc", out_acc, 32'h23232323);
    drain();

    // Three-beat frame.
    send_beat(32'h05050505, 32'h07070707, 1'b0);
    send_beat(32'h06060606, 32'h06060606, 1'b0);
    send_beat(32'h02020202, 32'h03030303, 1'b1);
    drain();

    // Wrap-around: single beat, then two beats in one frame.
    send_beat(32'hFAFAFAFA, 32'hFAFAFAFA, 1'b1);
    send_beat(32'hFAFAFAFA, 32'hFAFAFAFA, 1'b0);
    send_beat(32'hFAFAFAFA, 32'hFAFAFAFA, 1'b1);
    drain();

    // Unreduced residues (also trips the optional range check).
    send_beat(32'h00F20000, 32'h01010101, 1'b0);
    send_beat(32'hFFF0FB10, 32'hFEF2FC33, 1'b1);
    drain();

    // Backpressure: two single-beat frames held behind a stalled consumer.
    out_ready = 1'b0;
    send_beat(32'h11223344, 32'h05060708, 1'b1);
    send_beat(32'h0A0B0C0D, 32'h09080706, 1'b1);
    repeat (5) begin
      @(negedge clk);
      check("bp_in_ready",  32'(in_ready),  32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      if (exp_q.size() == 2) check("bp_out_acc_hold", out_acc, exp_q[0].acc);
      else                   check("bp_queue_depth", 32'(exp_q.size()), 32'd2);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    drain();

    // Counter saturation: 20 beats against a 4-bit counter.
    for (int k = 0; k < 20; k++)
      send_beat($urandom, $urandom, k == 19);
    drain();

    // Random frames of 1..4 reduced beats.
    for (int f = 0; f < 4; f++) begin
      int len;
      len = int'($urandom_range(1, 4));
      for (int k = 0; k < len; k++)
        send_beat({8'($urandom_range(0, 232)), 8'($urandom_range(0, 238)),
                   8'($urandom_range(0, 240)), 8'($urandom_range(0, 250))},
                  {8'($urandom_range(0, 232)), 8'($urandom_range(0, 238)),
                   8'($urandom_range(0, 240)), 8'($urandom_range(0, 250))},
                  k == len - 1);
    end
    drain();

    // Reset mid-frame discards the partial frame.
    send_beat(32'h05050505, 32'h07070707, 1'b0);
    send_beat(32'h06060606, 32'h06060606, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_state("midreset");
    rst_n = 1'b1;
    send_beat(32'h01010101, 32'h01010101, 1'b1);
    @(negedge clk);
    @(negedge clk);
    check("midreset_acc",   out_acc,          32'h01010101);
    check("midreset_count", 32'(out_count),   32'd1);
    drain();

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
